// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Bit positions inside the EX/MEM Mem control field
  localparam int unsigned MEM_BR  = 2;
  localparam int unsigned MEM_RD  = 1;
  localparam int unsigned MEM_WR  = 0;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STALL_W = 16;

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter for data-memory wait states; zero_c_o reports the
// counter value that will be held after this cycle's load/decrement.
module mem_wait_timer
  import hazard_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign zero_c_o = (cnt_d == '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, taken-branch flush, load-use stall.
// Define HAZARD_MEM_WAIT_EN to enable the data-memory wait-state freeze.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [4:0]         id_rs_i,
  input  logic [4:0]         id_rt_i,
  input  logic [4:0]         ex_rt_i,
  input  logic               ex_memread_i,
  input  logic [2:0]         mem_ctrl_i,
  input  logic               mem_zero_i,
  output logic               pc_write_o,
  output logic               ifid_write_o,
  output logic               idex_write_o,
  output logic               exmem_write_o,
  output logic               ifid_flush_o,
  output logic               idex_flush_o,
  output logic               exmem_flush_o,
  output logic               memwb_flush_o,
  output logic               pc_src_o,
  output logic [STALL_W-1:0] stall_cnt_o
);

  logic               freeze_c;
  logic               branch_c;
  logic               load_use_c;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  assign branch_c   = mem_ctrl_i[MEM_BR] & mem_zero_i;
  assign load_use_c = ex_memread_i && (ex_rt_i != '0) &&
                      ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

`ifdef HAZARD_MEM_WAIT_EN
  state_e state_q, state_d;
  logic   served_q, served_d;
  logic   access_c, tmr_load_c, tmr_dec_c, tmr_zero_c;

  assign access_c   = mem_ctrl_i[MEM_RD] | mem_ctrl_i[MEM_WR];
  assign tmr_load_c = (state_q == ST_RUN) && access_c && !served_q;
  assign tmr_dec_c  = (state_q == ST_WAIT);
  assign freeze_c   = tmr_load_c | tmr_dec_c;

  mem_wait_timer u_mem_wait_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load_c),
    .load_val_i (CNT_W'(MEM_WAIT - 1)),
    .dec_i      (tmr_dec_c),
    .zero_c_o   (tmr_zero_c)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_RUN;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      served_q <= served_d;
    end
  end

  // A single-cycle wait (timer loads zero) completes without visiting WAIT
  always_comb begin
    state_d  = state_q;
    served_d = served_q;
    unique case (state_q)
      ST_RUN: begin
        served_d = 1'b0;
        if (tmr_load_c) begin
          served_d = tmr_zero_c;
          if (!tmr_zero_c) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tmr_zero_c) begin
          state_d  = ST_RUN;
          served_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end
`else
  logic [CNT_W+1:0] unused_mem_wait_c;

  assign freeze_c          = 1'b0;
  assign unused_mem_wait_c = {CNT_W'(MEM_WAIT), mem_ctrl_i[MEM_RD], mem_ctrl_i[MEM_WR]};
`endif

  // Priority: freeze, taken branch, load-use; reset forces the idle pattern
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    idex_write_o  = 1'b1;
    exmem_write_o = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    memwb_flush_o = 1'b0;
    pc_src_o      = 1'b0;
    if (rst_i) begin
      if (freeze_c) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_write_o  = 1'b0;
        exmem_write_o = 1'b0;
        memwb_flush_o = 1'b1;
      end else if (branch_c) begin
        pc_src_o      = 1'b1;
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        exmem_flush_o = 1'b1;
      end else if (load_use_c) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_flush_o  = 1'b1;
      end
    end
  end

  assign stall_cnt_d = (!pc_write_o && (stall_cnt_q != '1)) ?
                       stall_cnt_q + STALL_W'(1) : stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl; follows HAZARD_MEM_WAIT_EN if defined.
module tb_hazard_ctrl;

  localparam int unsigned MEM_WAIT = 2;

  // {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, memwb_f, pc_src}
  localparam logic [8:0] CTL_DEF = 9'b1111_0000_0;
  localparam logic [8:0] CTL_FRZ = 9'b0000_0001_0;
  localparam logic [8:0] CTL_BR  = 9'b1111_1110_1;
  localparam logic [8:0] CTL_LU  = 9'b0011_0100_0;

  typedef struct packed {
    logic [8:0]  ctl;
    logic [15:0] stall;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  id_rs_i = '0, id_rt_i = '0, ex_rt_i = '0;
  logic        ex_memread_i = 1'b0;
  logic [2:0]  mem_ctrl_i = '0;
  logic        mem_zero_i = 1'b0;
  logic        pc_write_o, ifid_write_o, idex_write_o, exmem_write_o;
  logic        ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o;
  logic        pc_src_o;
  logic [15:0] stall_cnt_o;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        m_served = 1'b0;
  int unsigned m_left   = 0;
  logic [15:0] m_stall  = '0;

  hazard_ctrl #(.MEM_WAIT(MEM_WAIT)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .ex_rt_i       (ex_rt_i),
    .ex_memread_i  (ex_memread_i),
    .mem_ctrl_i    (mem_ctrl_i),
    .mem_zero_i    (mem_zero_i),
    .pc_write_o    (pc_write_o),
    .ifid_write_o  (ifid_write_o),
    .idex_write_o  (idex_write_o),
    .exmem_write_o (exmem_write_o),
    .ifid_flush_o  (ifid_flush_o),
    .idex_flush_o  (idex_flush_o),
    .exmem_flush_o (exmem_flush_o),
    .memwb_flush_o (memwb_flush_o),
    .pc_src_o      (pc_src_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One pipeline cycle: drive, predict, compare at negedge, advance model
  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] ert, input logic emr,
                      input logic [2:0] mc, input logic z);
    logic [8:0] ctl;
    logic       freeze, br, lu, acc;
    exp_t       e, got;
    rst_i = rst; id_rs_i = rs; id_rt_i = rt; ex_rt_i = ert;
    ex_memread_i = emr; mem_ctrl_i = mc; mem_zero_i = z;
    acc = mc[1] | mc[0];
    br  = mc[2] & z;
    lu  = emr && (ert != 5'd0) && ((ert == rs) || (ert == rt));
    if (!rst) begin
      m_served = 1'b0; m_left = 0; m_stall = '0;
    end
`ifdef HAZARD_MEM_WAIT_EN
    freeze = rst && ((m_left > 0) || (acc && !m_served));
`else
    freeze = 1'b0;
`endif
    if (!rst)        ctl = CTL_DEF;
    else if (freeze) ctl = CTL_FRZ;
    else if (br)     ctl = CTL_BR;
    else if (lu)     ctl = CTL_LU;
    else             ctl = CTL_DEF;
    e.ctl = ctl; e.stall = m_stall;
    exp_q.push_back(e);
    @(negedge clk_i);
    got.ctl = {pc_write_o, ifid_write_o, idex_write_o, exmem_write_o,
               ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o, pc_src_o};
    got.stall = stall_cnt_o;
    check("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("ctl", 32'(got.ctl), 32'(e.ctl));
      check("stall_cnt", 32'(got.stall), 32'(e.stall));
    end
    if (rst) begin
      if (!ctl[8] && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) m_served = 1'b1;
      end else begin
        m_served = freeze && (MEM_WAIT == 1);
        if (freeze) m_left = MEM_WAIT - 1;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset asserted with hazardous inputs: idle pattern, count 0
    step(1'b0, 5'd2, 5'd4, 5'd2, 1'b1, 3'b110, 1'b1);
    step(1'b0, 5'd2, 5'd4, 5'd2, 1'b1, 3'b100, 1'b1);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b0);
    // lw $2 ; add $3,$2,$4 then the bubble
    step(1'b1, 5'd2, 5'd4, 5'd2, 1'b1, 3'b000, 1'b0);
    step(1'b1, 5'd2, 5'd4, 5'd3, 1'b0, 3'b000, 1'b0);
    // $zero destination never stalls
    step(1'b1, 5'd0, 5'd7, 5'd0, 1'b1, 3'b000, 1'b0);
    // match on rt
    step(1'b1, 5'd9, 5'd5, 5'd5, 1'b1, 3'b000, 1'b0);
    // branch taken / not taken
    step(1'b1, 5'd1, 5'd1, 5'd3, 1'b0, 3'b100, 1'b1);
    step(1'b1, 5'd1, 5'd1, 5'd3, 1'b0, 3'b100, 1'b0);
    // branch and load-use together: branch only, no deferral
    step(1'b1, 5'd6, 5'd1, 5'd6, 1'b1, 3'b100, 1'b1);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b0);
    // held load access: freeze, serve, re-freeze
    for (int i = 0; i < 7; i++) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 3'b010, 1'b0);
    // freeze coincident with branch and load-use held throughout
    for (int i = 0; i < 4; i++) step(1'b1, 5'd8, 5'd1, 5'd8, 1'b1, 3'b101, 1'b1);
    step(1'b1, 5'd8, 5'd1, 5'd8, 1'b1, 3'b000, 1'b0);
    // reset during the first wait cycle, then a full fresh wait
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 3'b001, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b001, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 3'b001, 1'b0);
    // random mix with occasional reset
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    // drive the stall counter into saturation and hold it there
    for (int i = 0; i < 65540; i++) step(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 3'b000, 1'b0);
    check("stall_sat", 32'(stall_cnt_o), 32'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
